// File: rtl/sample_packetiser_if.sv
// 32-bit AXI4-Stream link carrying sample packets from the packetiser to the DMA path.
interface sample_packetiser_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/sample_packetiser.sv
// Latches four 64-bit accumulators and four 32-bit counts on a trigger pulse and
// streams them, with a magic header and sequence number, as one 14-word packet.
module sample_packetiser #(
  parameter logic [31:0] HEADER_MAGIC = 32'hA5A5_0001,
  parameter logic [31:0] SEQ_INIT     = 32'd0
) (
  input  logic                 aclk,
  input  logic                 rst,
  input  logic                 trigger,
  input  logic [63:0]          val_1,
  input  logic [63:0]          val_2,
  input  logic [63:0]          val_3,
  input  logic [63:0]          val_4,
  input  logic [31:0]          cnt_1,
  input  logic [31:0]          cnt_2,
  input  logic [31:0]          cnt_3,
  input  logic [31:0]          cnt_4,
  sample_packetiser_if.master  m_axis,
  output logic                 busy,
  output logic [15:0]          drop_count
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [3:0] LAST_IDX = 4'd13;

  state_t      r_state;
  logic [3:0]  r_idx;
  logic [31:0] r_seq;
  logic [63:0] r_val [4];
  logic [31:0] r_cnt [4];
  logic [31:0] r_tdata;
  logic        r_tvalid;
  logic        r_tlast;
  logic        r_busy;
  logic [15:0] r_drop;

  logic [3:0]  w_nidx;
  logic [31:0] w_next_word;
  logic        w_hs;

  assign w_hs   = r_tvalid & m_axis.tready;
  assign w_nidx = r_idx + 4'd1;

  // Word index 0 is loaded directly on trigger, so only indices 1..13 are selected here.
  always_comb begin
    w_next_word = 32'd0;
    case (w_nidx)
      4'd1:    w_next_word = r_seq;
      4'd2:    w_next_word = r_val[0][63:32];
      4'd3:    w_next_word = r_val[0][31:0];
      4'd4:    w_next_word = r_cnt[0];
      4'd5:    w_next_word = r_val[1][63:32];
      4'd6:    w_next_word = r_val[1][31:0];
      4'd7:    w_next_word = r_cnt[1];
      4'd8:    w_next_word = r_val[2][63:32];
      4'd9:    w_next_word = r_val[2][31:0];
      4'd10:   w_next_word = r_cnt[2];
      4'd11:   w_next_word = r_val[3][63:32];
      4'd12:   w_next_word = r_val[3][31:0];
      4'd13:   w_next_word = r_cnt[3];
      default: w_next_word = 32'd0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_idx    <= 4'd0;
      r_seq    <= SEQ_INIT;
      r_tdata  <= 32'd0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_busy   <= 1'b0;
      r_drop   <= 16'd0;
      for (int i = 0; i < 4; i++) begin
        r_val[i] <= 64'd0;
        r_cnt[i] <= 32'd0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (trigger) begin
            r_val[0] <= val_1;
            r_val[1] <= val_2;
            r_val[2] <= val_3;
            r_val[3] <= val_4;
            r_cnt[0] <= cnt_1;
            r_cnt[1] <= cnt_2;
            r_cnt[2] <= cnt_3;
            r_cnt[3] <= cnt_4;
            r_idx    <= 4'd0;
            r_tdata  <= HEADER_MAGIC;
            r_tvalid <= 1'b1;
            r_tlast  <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= SEND;
          end
        end
        SEND: begin
          // Triggers during a packet, including its final handshake cycle, are lost.
          if (trigger && r_drop != 16'hFFFF) begin
            r_drop <= r_drop + 16'd1;
          end
          if (w_hs) begin
            if (r_idx == LAST_IDX) begin
              r_idx    <= 4'd0;
              r_tdata  <= 32'd0;
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
              r_busy   <= 1'b0;
              r_seq    <= r_seq + 32'd1;
              r_state  <= IDLE;
            end else begin
              r_idx   <= w_nidx;
              r_tdata <= w_next_word;
              r_tlast <= (w_nidx == LAST_IDX);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_axis.tdata  = r_tdata;
  assign m_axis.tvalid = r_tvalid;
  assign m_axis.tlast  = r_tlast;
  assign busy          = r_busy;
  assign drop_count    = r_drop;

endmodule

// File: tb/tb_sample_packetiser.sv
// Drives two packetisers (SEQ_INIT 0 and FFFFFFFF) with directed and random stimulus
// and compares every cycle against a queue-based packet model.
module tb_sample_packetiser;

  logic        aclk = 1'b0;
  logic        rst;
  logic        trigger;
  logic        tready;
  logic [63:0] val [4];
  logic [31:0] cnt [4];
  logic [15:0] drop0, drop1;
  logic        busy0, busy1;

  int n_tests = 0;
  int n_fail  = 0;

  sample_packetiser_if s0 ();
  sample_packetiser_if s1 ();

  assign s0.tready = tready;
  assign s1.tready = tready;

  always #5 aclk = ~aclk;

  sample_packetiser #(.HEADER_MAGIC(32'hA5A5_0001), .SEQ_INIT(32'd0)) dut0 (
    .aclk(aclk), .rst(rst), .trigger(trigger),
    .val_1(val[0]), .val_2(val[1]), .val_3(val[2]), .val_4(val[3]),
    .cnt_1(cnt[0]), .cnt_2(cnt[1]), .cnt_3(cnt[2]), .cnt_4(cnt[3]),
    .m_axis(s0), .busy(busy0), .drop_count(drop0)
  );

  sample_packetiser #(.HEADER_MAGIC(32'hA5A5_0001), .SEQ_INIT(32'hFFFF_FFFF)) dut1 (
    .aclk(aclk), .rst(rst), .trigger(trigger),
    .val_1(val[0]), .val_2(val[1]), .val_3(val[2]), .val_4(val[3]),
    .cnt_1(cnt[0]), .cnt_2(cnt[1]), .cnt_3(cnt[2]), .cnt_4(cnt[3]),
    .m_axis(s1), .busy(busy1), .drop_count(drop1)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a packet is just the list of words still owed downstream.
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] seq0, seq1;
  logic [15:0] drop_m;
  bit          armed = 1'b0;

  always @(negedge aclk) begin
    if (armed) begin
      check_val("tvalid0", 32'(s0.tvalid), 32'(q0.size() != 0));
      check_val("busy0",   32'(busy0),     32'(q0.size() != 0));
      check_val("tlast0",  32'(s0.tlast),  32'(q0.size() == 1));
      if (q0.size() != 0) check_val("tdata0", s0.tdata, q0[0]);
      check_val("tvalid1", 32'(s1.tvalid), 32'(q1.size() != 0));
      check_val("tlast1",  32'(s1.tlast),  32'(q1.size() == 1));
      if (q1.size() != 0) check_val("tdata1", s1.tdata, q1[0]);
      check_val("drop0", 32'(drop0), 32'(drop_m));
      check_val("drop1", 32'(drop1), 32'(drop_m));
    end
    if (!rst) begin
      q0.delete();
      q1.delete();
      seq0   = 32'd0;
      seq1   = 32'hFFFF_FFFF;
      drop_m = 16'd0;
      armed  = 1'b1;
    end else if (q0.size() != 0) begin
      if (trigger && drop_m != 16'hFFFF) drop_m = drop_m + 16'd1;
      if (tready) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
        if (q0.size() == 0) begin
          seq0 = seq0 + 32'd1;
          seq1 = seq1 + 32'd1;
        end
      end
    end else if (trigger) begin
      q0.push_back(32'hA5A5_0001);
      q1.push_back(32'hA5A5_0001);
      q0.push_back(seq0);
      q1.push_back(seq1);
      for (int ch = 0; ch < 4; ch++) begin
        q0.push_back(val[ch][63:32]);
        q0.push_back(val[ch][31:0]);
        q0.push_back(cnt[ch]);
        q1.push_back(val[ch][63:32]);
        q1.push_back(val[ch][31:0]);
        q1.push_back(cnt[ch]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic randomise_inputs();
    for (int ch = 0; ch < 4; ch++) begin
      val[ch] = {$urandom, $urandom};
      cnt[ch] = $urandom;
    end
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    tick(1);
    trigger = 1'b0;
  endtask

  initial begin
    rst     = 1'b0;
    trigger = 1'b0;
    tready  = 1'b0;
    randomise_inputs();
    tick(3);
    rst = 1'b1;
    tick(2);

    // Known packet, continuous ready
    val[0] = 64'h1234_5678_ABCD_EF01; cnt[0] = 32'd1;
    val[1] = 64'h0000_0002_0000_0003; cnt[1] = 32'd2;
    val[2] = 64'hFFFF_FFFF_0000_0000; cnt[2] = 32'd3;
    val[3] = 64'h8000_0000_7FFF_FFFF; cnt[3] = 32'd4;
    tready = 1'b1;
    pulse_trigger();
    randomise_inputs();
    tick(20);

    // Same content with ready toggling every cycle
    val[0] = 64'h1234_5678_ABCD_EF01; cnt[0] = 32'd1;
    pulse_trigger();
    for (int i = 0; i < 40; i++) begin
      tready = ~tready;
      tick(1);
    end
    tready = 1'b1;
    tick(5);

    // Two triggers 125 cycles apart
    pulse_trigger();
    tick(124);
    pulse_trigger();
    tick(20);

    // Triggers 5 cycles into the packet and on the final handshake cycle
    pulse_trigger();
    tick(4);
    pulse_trigger();
    tick(8);
    pulse_trigger();
    tick(5);

    // Reset on the beat-6 handshake, then a fresh packet
    pulse_trigger();
    tick(6);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(3);
    randomise_inputs();
    pulse_trigger();
    tick(20);

    // Random traffic: inputs churn every cycle, ready and trigger random
    for (int i = 0; i < 600; i++) begin
      randomise_inputs();
      tready  = ($urandom_range(0, 3) != 0);
      trigger = ($urandom_range(0, 11) == 0);
      tick(1);
    end
    trigger = 1'b0;
    tready  = 1'b1;
    tick(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
